debouncer_bank: RTL and testbench

- Parametrised N-channel input conditioner; supersedes the fixed one- and two-channel debouncers.
- Each channel has a configurable-depth synchroniser, a stability counter with optional sample-enable prescaling, per-channel reset level, one-cycle rise/fall strobes and a busy flag.
- Sits between raw board pins (PS/2 clock/data, UART RX, buttons) and the SoC, in the board clock domain.

---
 rtl/debouncer_bank.sv | 86 ++++++++
 tb/tb_debouncer_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_bank.sv
// debouncer_bank: N-channel input conditioner for raw board pins.
// Each channel synchronises its pin, requires 2^COUNTER_BITS consecutive
// enabled mismatch samples before the debounced level follows, and emits
// one-cycle rise/fall strobes when the level changes.
module debouncer_bank #(
  parameter int                  CHANNELS     = 2,
  parameter int                  COUNTER_BITS = 5,
  parameter int                  SYNC_STAGES  = 2,
  parameter logic [CHANNELS-1:0] RESET_VALUE  = '1
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                sampleEn,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] busy
);

  localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;

  // Synchroniser chain; stage 0 is the only reader of the raw pins.
  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [CHANNELS-1:0] w_s;

  // Shift raw pins through the synchroniser, preset to the idle level.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= RESET_VALUE;
      end
    end else begin
      r_sync[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [COUNTER_BITS-1:0] r_cnt;
    logic                    r_out;
    logic                    r_rise;
    logic                    r_fall;
    logic                    w_diff;

    assign w_diff = w_s[g] ^ r_out;

    // Stability counter: any matching sample restarts the window; the
    // level only moves on the enabled sample that finds the counter full,
    // so the counter can never wrap.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        r_cnt  <= '0;
        r_out  <= RESET_VALUE[g];
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        if (!w_diff) begin
          r_cnt <= '0;
        end else if (sampleEn) begin
          if (r_cnt == CNT_MAX) begin
            r_out  <= w_s[g];
            r_cnt  <= '0;
            r_rise <= w_s[g];
            r_fall <= ~w_s[g];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end

    assign out[g]  = r_out;
    assign rise[g] = r_rise;
    assign fall[g] = r_fall;
    // Pending change: synchronised level disagrees with the debounced one.
    assign busy[g] = w_diff;
  end

endmodule

// File: tb/tb_debouncer_bank.sv
module tb_debouncer_bank;

  localparam int NCH  = 2;
  localparam int B_CB = 4;
  localparam int B_SS = 2;
  localparam int C_CB = 1;
  localparam int C_SS = 3;

  logic clk = 1'b0;
  logic resetN = 1'b0;

  logic           a_en, b_en, c_en;
  logic [NCH-1:0] a_in, a_out, a_rise, a_fall, a_busy;
  logic [NCH-1:0] b_in, b_out, b_rise, b_fall, b_busy;
  logic [NCH-1:0] c_in, c_out, c_rise, c_fall, c_busy;

  always #5 clk = ~clk;

  debouncer_bank #(.CHANNELS(NCH)) dut_a (
    .clk(clk), .resetN(resetN), .sampleEn(a_en), .in(a_in),
    .out(a_out), .rise(a_rise), .fall(a_fall), .busy(a_busy));

  debouncer_bank #(.CHANNELS(NCH), .COUNTER_BITS(B_CB), .SYNC_STAGES(B_SS)) dut_b (
    .clk(clk), .resetN(resetN), .sampleEn(b_en), .in(b_in),
    .out(b_out), .rise(b_rise), .fall(b_fall), .busy(b_busy));

  debouncer_bank #(.CHANNELS(NCH), .COUNTER_BITS(C_CB), .SYNC_STAGES(C_SS)) dut_c (
    .clk(clk), .resetN(resetN), .sampleEn(c_en), .in(c_in),
    .out(c_out), .rise(c_rise), .fall(c_fall), .busy(c_busy));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    a_in = '1; b_in = '1; c_in = '1;
    a_en = 1'b1; b_en = 1'b1; c_en = 1'b1;
    tick();
    tick();
    resetN = 1'b1;
  endtask

  // Behavioural reference for dut_b: the synchroniser is a plain delay line,
  // and the level follows on the 2^B_CB-th consecutive enabled mismatch.
  logic [NCH-1:0] m_hist [B_SS];
  logic [NCH-1:0] m_out, m_rise, m_fall;
  int             m_nmis [NCH];

  task automatic model_reset();
    for (int k = 0; k < B_SS; k++) m_hist[k] = '1;
    m_out  = '1;
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < NCH; c++) m_nmis[c] = 0;
  endtask

  task automatic model_step(input logic [NCH-1:0] pin, input logic en);
    logic [NCH-1:0] s_seen;
    s_seen = m_hist[B_SS-1];
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < NCH; c++) begin
      if (s_seen[c] == m_out[c]) begin
        m_nmis[c] = 0;
      end else if (en) begin
        m_nmis[c] = m_nmis[c] + 1;
        if (m_nmis[c] == (1 << B_CB)) begin
          m_out[c]  = s_seen[c];
          m_rise[c] = s_seen[c];
          m_fall[c] = ~s_seen[c];
          m_nmis[c] = 0;
        end
      end
    end
    for (int k = B_SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = pin;
  endtask

  typedef struct {
    logic [1:0] vin;
    logic       ven;
    logic [1:0] vout;
    logic [1:0] vrise;
    logic [1:0] vfall;
    logic [1:0] vbusy;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [NCH-1:0] r_in;
    logic           r_en;
    logic           x_out, x_fall, x_rise, x_busy;
    logic [1:0]     e_out, e_fall, e_rise, e_busy;

    // Minimum configuration (COUNTER_BITS=1, SYNC_STAGES=3), channel 1 idle.
    tbl[0]  = '{2'b10, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{2'b10, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{2'b10, 1'b1, 2'b11, 2'b00, 2'b00, 2'b01};
    tbl[3]  = '{2'b10, 1'b1, 2'b11, 2'b00, 2'b00, 2'b01};
    tbl[4]  = '{2'b10, 1'b1, 2'b10, 2'b00, 2'b01, 2'b00};
    tbl[5]  = '{2'b10, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[6]  = '{2'b11, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[7]  = '{2'b10, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[8]  = '{2'b10, 1'b1, 2'b10, 2'b00, 2'b00, 2'b01};
    tbl[9]  = '{2'b10, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[10] = '{2'b10, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[11] = '{2'b10, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[12] = '{2'b11, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[13] = '{2'b11, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[14] = '{2'b11, 1'b1, 2'b10, 2'b00, 2'b00, 2'b01};
    tbl[15] = '{2'b11, 1'b1, 2'b10, 2'b00, 2'b00, 2'b01};
    tbl[16] = '{2'b11, 1'b1, 2'b11, 2'b01, 2'b00, 2'b00};
    tbl[17] = '{2'b11, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00};

    // Reset state with inputs low: outputs must still sit at the idle level.
    a_in = 2'b00; b_in = 2'b00; c_in = 2'b00;
    a_en = 1'b1; b_en = 1'b1; c_en = 1'b1;
    resetN = 1'b0;
    tick();
    tick();
    chk("rst a_out", a_out, 2'b11);
    chk("rst a_rise", a_rise, 2'b00);
    chk("rst a_fall", a_fall, 2'b00);
    chk("rst a_busy", a_busy, 2'b00);
    chk("rst b_out", b_out, 2'b11);
    chk("rst c_out", c_out, 2'b11);

    // Default config: async reset at counter=7, then full latency of 33.
    do_reset();
    a_in = 2'b00;
    for (int e = 0; e <= 8; e++) tick();
    chk("a busy pre-rst", a_busy, 2'b11);
    #1 resetN = 1'b0;
    #1;
    chk("a midrst out", a_out, 2'b11);
    chk("a midrst busy", a_busy, 2'b00);
    chk("a midrst rise", a_rise, 2'b00);
    chk("a midrst fall", a_fall, 2'b00);
    #1 resetN = 1'b1;
    for (int e = 0; e <= 34; e++) begin
      tick();
      e_out  = (e < 33) ? 2'b11 : 2'b00;
      e_fall = (e == 33) ? 2'b11 : 2'b00;
      e_busy = (e >= 1 && e < 33) ? 2'b11 : 2'b00;
      chk($sformatf("a out e%0d", e), a_out, e_out);
      chk($sformatf("a fall e%0d", e), a_fall, e_fall);
      chk($sformatf("a rise e%0d", e), a_rise, 2'b00);
      chk($sformatf("a busy e%0d", e), a_busy, e_busy);
    end

    // Clean fall and channel independence on dut_b.
    do_reset();
    for (int e = 0; e <= 59; e++) begin
      r_in = b_in;
      if (e == 0)  r_in[0] = 1'b0;
      if (e == 5)  r_in[1] = 1'b0;
      if (e == 40) r_in = 2'b11;
      b_in = r_in;
      tick();
      e_out[0]  = (e < 17) || (e >= 57);
      e_out[1]  = (e < 22) || (e >= 57);
      e_fall[0] = (e == 17);
      e_fall[1] = (e == 22);
      e_rise    = (e == 57) ? 2'b11 : 2'b00;
      e_busy[0] = (e >= 1 && e < 17) || (e >= 41 && e < 57);
      e_busy[1] = (e >= 6 && e < 22) || (e >= 41 && e < 57);
      chk($sformatf("ind out e%0d", e), b_out, e_out);
      chk($sformatf("ind fall e%0d", e), b_fall, e_fall);
      chk($sformatf("ind rise e%0d", e), b_rise, e_rise);
      chk($sformatf("ind busy e%0d", e), b_busy, e_busy);
    end

    // Glitch rejection: one high sample after 10 low ones restarts the window.
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      b_in = {1'b1, (e == 10)};
      tick();
      x_out  = (e < 28);
      x_fall = (e == 28);
      x_busy = (e >= 1 && e <= 10) || (e >= 12 && e < 28);
      chk($sformatf("glt out e%0d", e), b_out[0], x_out);
      chk($sformatf("glt fall e%0d", e), b_fall[0], x_fall);
      chk($sformatf("glt rise e%0d", e), b_rise, 2'b00);
      chk($sformatf("glt busy e%0d", e), b_busy[0], x_busy);
    end

    // Prescaled sampling: enable every 4th edge; a matching sample on a
    // disabled edge still clears the count.
    do_reset();
    for (int e = 0; e <= 137; e++) begin
      b_en = ((e % 4) == 3);
      b_in = {1'b1, !(e < 64 || e == 72)};
      tick();
      x_out  = (e < 63) || (e >= 135);
      x_fall = (e == 63);
      x_rise = (e == 135);
      x_busy = (e >= 1 && e < 63) || (e >= 65 && e < 135 && e != 73);
      chk($sformatf("pre out e%0d", e), b_out[0], x_out);
      chk($sformatf("pre fall e%0d", e), b_fall[0], x_fall);
      chk($sformatf("pre rise e%0d", e), b_rise[0], x_rise);
      chk($sformatf("pre busy e%0d", e), b_busy[0], x_busy);
    end

    // Minimum configuration from the vector table.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      c_in = tbl[i].vin;
      c_en = tbl[i].ven;
      tick();
      chk($sformatf("min out v%0d", i), c_out, tbl[i].vout);
      chk($sformatf("min rise v%0d", i), c_rise, tbl[i].vrise);
      chk($sformatf("min fall v%0d", i), c_fall, tbl[i].vfall);
      chk($sformatf("min busy v%0d", i), c_busy, tbl[i].vbusy);
    end

    // Randomised stimulus on dut_b against the reference model.
    do_reset();
    model_reset();
    r_in = '1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 39) == 0) r_in[c] = ~r_in[c];
      end
      r_en = ($urandom_range(0, 3) != 0);
      b_in = r_in;
      b_en = r_en;
      tick();
      model_step(r_in, r_en);
      chk($sformatf("rnd out c%0d", cyc), b_out, m_out);
      chk($sformatf("rnd rise c%0d", cyc), b_rise, m_rise);
      chk($sformatf("rnd fall c%0d", cyc), b_fall, m_fall);
      chk($sformatf("rnd busy c%0d", cyc), b_busy, m_hist[B_SS-1] ^ m_out);
      if ($urandom_range(0, 599) == 0) begin
        #1 resetN = 1'b0;
        #1;
        model_reset();
        chk($sformatf("rnd rst out c%0d", cyc), b_out, m_out);
        chk($sformatf("rnd rst busy c%0d", cyc), b_busy, 2'b00);
        #1 resetN = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
